multicycle_ctrl: RTL and testbench

Finite-state controller that sequences the shared multi-cycle RV32 datapath through fetch, decode, execute, memory and write-back. It drives the register, ALU, memory and PC enables and muxes, and the format select of the immediate sign-extender. One memory port with a request/acknowledge handshake serves both instruction fetch and data access. The controller sits between the instruction register and the datapath mux/enable network.

---
 rtl/multicycle_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 controller: sequences fetch/decode/execute/memory/write-back over one shared datapath.
// Define MULTICYCLE_CTRL_PERF_EN to build the retired-instruction counter; otherwise instr_count_o is 0.
module multicycle_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] instr_i,
  input  logic        zero_i,
  input  logic        mem_ack_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        mem_addr_sel_o,
  output logic        ir_write_o,
  output logic        pc_write_o,
  output logic        pc_src_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [1:0]  alu_op_o,
  output logic [2:0]  imm_sel_o,
  output logic        reg_write_o,
  output logic        wb_sel_o,
  output logic [2:0]  state_o,
  output logic        busy_o,
  output logic        illegal_o,
  output logic [31:0] instr_count_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EX     = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  state_t     state_q;
  state_t     state_d;
  logic [6:0] op_q;

  // Only the opcode field steers the sequence; the rest belongs to the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr_i[31:7];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) begin
        op_q <= instr_i[6:0];
      end
    end
  end

  // NOTE: every output and state_d gets a default first so no path infers a latch.
  always_comb begin
    state_d        = state_q;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_sel_o = 1'b0;
    ir_write_o     = 1'b0;
    pc_write_o     = 1'b0;
    pc_src_o       = 1'b0;
    alu_src_a_o    = 1'b0;
    alu_src_b_o    = 2'b00;
    alu_op_o       = 2'b00;
    reg_write_o    = 1'b0;
    wb_sel_o       = 1'b0;
    illegal_o      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        mem_req_o   = 1'b1;
        alu_src_b_o = 2'b01;
        if (mem_ack_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = ST_DECODE;
        end
      end

      ST_DECODE: begin
        case (instr_i[6:0])
          OP_R, OP_I, OP_LD, OP_SD, OP_BEQ: state_d = ST_EX;
          default:                          state_d = ST_HALT;
        endcase
      end

      ST_EX: begin
        alu_src_a_o = 1'b1;
        case (op_q)
          OP_R: begin
            alu_src_b_o = 2'b00;
            alu_op_o    = 2'b10;
            state_d     = ST_WB;
          end
          OP_I: begin
            alu_src_b_o = 2'b10;
            alu_op_o    = 2'b10;
            state_d     = ST_WB;
          end
          OP_LD, OP_SD: begin
            alu_src_b_o = 2'b10;
            alu_op_o    = 2'b00;
            state_d     = ST_MEM;
          end
          OP_BEQ: begin
            alu_src_b_o = 2'b00;
            alu_op_o    = 2'b01;
            if (zero_i) begin
              pc_write_o = 1'b1;
              pc_src_o   = 1'b1;
            end
            state_d = ST_FETCH;
          end
          default: state_d = ST_HALT;
        endcase
      end

      ST_MEM: begin
        mem_req_o      = 1'b1;
        mem_addr_sel_o = 1'b1;
        mem_we_o       = (op_q == OP_SD);
        if (mem_ack_i) begin
          state_d = (op_q == OP_SD) ? ST_FETCH : ST_WB;
        end
      end

      ST_WB: begin
        reg_write_o = 1'b1;
        wb_sel_o    = (op_q == OP_LD);
        state_d     = ST_FETCH;
      end

      ST_HALT: begin
        illegal_o = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Immediate format follows the latched opcode, independent of state.
  always_comb begin
    case (op_q)
      OP_I, OP_LD: imm_sel_o = 3'b001;
      OP_SD:       imm_sel_o = 3'b010;
      OP_BEQ:      imm_sel_o = 3'b011;
      default:     imm_sel_o = 3'b000;
    endcase
  end

  assign state_o = state_q;
  assign busy_o  = (state_q == ST_FETCH) || (state_q == ST_DECODE) || (state_q == ST_EX) ||
                   (state_q == ST_MEM)   || (state_q == ST_WB);

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic        retire;
  logic [31:0] count_q;

  assign retire = (state_q == ST_WB) ||
                  ((state_q == ST_MEM) && (op_q == OP_SD) && mem_ack_i) ||
                  ((state_q == ST_EX) && (op_q == OP_BEQ));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (retire) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign instr_count_o = count_q;
`else
  assign instr_count_o = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues hand-derived per-cycle expectations,
// a negedge monitor pops and compares the full output bundle.
module tb_multicycle_ctrl;

`ifdef MULTICYCLE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]  state;
    logic        mem_req;
    logic        mem_we;
    logic        addr_sel;
    logic        ir_write;
    logic        pc_write;
    logic        pc_src;
    logic        src_a;
    logic [1:0]  src_b;
    logic [1:0]  alu_op;
    logic [2:0]  imm;
    logic        reg_write;
    logic        wb_sel;
    logic        busy;
    logic        illegal;
    logic [31:0] count;
  } ctl_t;

  typedef struct {
    string name;
    ctl_t  exp;
  } item_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] instr;
  logic        zero;
  logic        ack;
  logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, alu_src_a;
  logic [1:0]  alu_src_b, alu_op;
  logic [2:0]  imm_sel, state;
  logic        reg_write, wb_sel, busy, illegal;
  logic [31:0] instr_count;

  multicycle_ctrl dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .instr_i(instr), .zero_i(zero),
    .mem_ack_i(ack), .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_sel_o(mem_addr_sel),
    .ir_write_o(ir_write), .pc_write_o(pc_write), .pc_src_o(pc_src), .alu_src_a_o(alu_src_a),
    .alu_src_b_o(alu_src_b), .alu_op_o(alu_op), .imm_sel_o(imm_sel), .reg_write_o(reg_write),
    .wb_sel_o(wb_sel), .state_o(state), .busy_o(busy), .illegal_o(illegal),
    .instr_count_o(instr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  item_t      sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         exp_cnt;
  logic [2:0] cur_imm;

  // Monitor: one expectation per cycle, sampled mid-cycle.
  ctl_t  act;
  item_t cur;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      act.state     = state;
      act.mem_req   = mem_req;
      act.mem_we    = mem_we;
      act.addr_sel  = mem_addr_sel;
      act.ir_write  = ir_write;
      act.pc_write  = pc_write;
      act.pc_src    = pc_src;
      act.src_a     = alu_src_a;
      act.src_b     = alu_src_b;
      act.alu_op    = alu_op;
      act.imm       = imm_sel;
      act.reg_write = reg_write;
      act.wb_sel    = wb_sel;
      act.busy      = busy;
      act.illegal   = illegal;
      act.count     = instr_count;
      n_cmp++;
      if (act !== cur.exp) begin
        n_bad++;
        $display("FAIL %s: got {state,ctl}=%0d,%h cnt=%0d, expected %0d,%h cnt=%0d", cur.name,
                 act.state, act[48:32], act.count, cur.exp.state, cur.exp[48:32], cur.exp.count);
      end
    end
  end

  function automatic ctl_t base(input logic [2:0] st);
    ctl_t e;
    e         = '0;
    e.state   = st;
    e.busy    = (st >= 3'd1) && (st <= 3'd5);
    e.illegal = (st == 3'd6);
    e.imm     = cur_imm;
    e.count   = exp_cnt;
    return e;
  endfunction

  task automatic step(input string name, input ctl_t e, input logic s_start,
                      input logic s_ack, input logic s_zero, input logic s_rst);
    item_t it;
    start   = s_start;
    ack     = s_ack;
    zero    = s_zero;
    rst     = s_rst;
    it.name = name;
    it.exp  = e;
    sb.push_back(it);
    @(posedge clk);
    #1;
  endtask

  task automatic bump();
    if (PERF) exp_cnt++;
  endtask

  task automatic do_fetch(input logic [31:0] ins, input int waits);
    ctl_t e;
    instr = ins;
    for (int i = 0; i < waits; i++) begin
      e = base(3'd1); e.mem_req = 1'b1; e.src_b = 2'b01;
      step("fetch_wait", e, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    e = base(3'd1); e.mem_req = 1'b1; e.src_b = 2'b01; e.ir_write = 1'b1; e.pc_write = 1'b1;
    step("fetch_ack", e, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // ack held high in DECODE: it must be ignored there.
  task automatic do_decode(input logic [2:0] imm_new);
    step("decode", base(3'd2), 1'b0, 1'b1, 1'b0, 1'b0);
    cur_imm = imm_new;
  endtask

  task automatic do_r();
    ctl_t e;
    do_fetch(32'h002081B3, 0);
    do_decode(3'b000);
    e = base(3'd3); e.src_a = 1'b1; e.src_b = 2'b00; e.alu_op = 2'b10;
    step("r_ex", e, 1'b0, 1'b0, 1'b0, 1'b0);
    e = base(3'd5); e.reg_write = 1'b1;
    step("r_wb", e, 1'b0, 1'b1, 1'b0, 1'b0);
    bump();
  endtask

  task automatic do_ld(input int waits);
    ctl_t e;
    do_fetch(32'h0000A103, 0);
    do_decode(3'b001);
    e = base(3'd3); e.src_a = 1'b1; e.src_b = 2'b10; e.alu_op = 2'b00;
    step("ld_ex", e, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < waits; i++) begin
      e = base(3'd4); e.mem_req = 1'b1; e.addr_sel = 1'b1;
      step("ld_mem_wait", e, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    e = base(3'd4); e.mem_req = 1'b1; e.addr_sel = 1'b1;
    step("ld_mem_ack", e, 1'b0, 1'b1, 1'b0, 1'b0);
    e = base(3'd5); e.reg_write = 1'b1; e.wb_sel = 1'b1;
    step("ld_wb", e, 1'b0, 1'b0, 1'b0, 1'b0);
    bump();
  endtask

  task automatic do_sd();
    ctl_t e;
    do_fetch(32'h0020A023, 0);
    do_decode(3'b010);
    e = base(3'd3); e.src_a = 1'b1; e.src_b = 2'b10; e.alu_op = 2'b00;
    step("sd_ex", e, 1'b0, 1'b0, 1'b0, 1'b0);
    e = base(3'd4); e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_we = 1'b1;
    step("sd_mem_ack", e, 1'b0, 1'b1, 1'b0, 1'b0);
    bump();
  endtask

  task automatic do_beq(input logic z);
    ctl_t e;
    do_fetch(32'h00208463, 0);
    do_decode(3'b011);
    e = base(3'd3); e.src_a = 1'b1; e.src_b = 2'b00; e.alu_op = 2'b01;
    e.pc_write = z; e.pc_src = z;
    step(z ? "beq_taken_ex" : "beq_not_taken_ex", e, 1'b0, 1'b0, z, 1'b0);
    bump();
  endtask

  initial begin
    ctl_t e;
    rst     = 1'b1;
    start   = 1'b0;
    ack     = 1'b0;
    zero    = 1'b0;
    instr   = '0;
    exp_cnt = 0;
    cur_imm = 3'b000;
    @(posedge clk);
    #1;

    step("reset_idle", base(3'd0), 1'b0, 1'b0, 1'b0, 1'b0);
    step("idle_start", base(3'd0), 1'b1, 1'b0, 1'b0, 1'b0);
    do_r();
    do_ld(2);
    do_sd();
    do_beq(1'b1);
    do_beq(1'b0);

    // Illegal opcode: HALT is sticky until reset.
    do_fetch(32'h0000007F, 1);
    do_decode(3'b000);
    e = base(3'd6);
    step("halt_start_ignored", e, 1'b1, 1'b0, 1'b0, 1'b0);
    step("halt_ack_ignored", e, 1'b1, 1'b1, 1'b1, 1'b0);
    step("halt_rst", e, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_cnt = 0;
    cur_imm = 3'b000;
    step("halt_to_idle", base(3'd0), 1'b0, 1'b0, 1'b0, 1'b0);
    step("idle_start2", base(3'd0), 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset during a stalled ld MEM aborts with no write-back.
    do_fetch(32'h0000A103, 1);
    do_decode(3'b001);
    e = base(3'd3); e.src_a = 1'b1; e.src_b = 2'b10; e.alu_op = 2'b00;
    step("abort_ld_ex", e, 1'b0, 1'b0, 1'b0, 1'b0);
    e = base(3'd4); e.mem_req = 1'b1; e.addr_sel = 1'b1;
    step("abort_mem_wait", e, 1'b0, 1'b0, 1'b0, 1'b0);
    step("abort_mem_rst", e, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_cnt = 0;
    cur_imm = 3'b000;
    step("abort_idle", base(3'd0), 1'b0, 1'b0, 1'b0, 1'b0);
    step("abort_idle_hold", base(3'd0), 1'b0, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
